// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide engine for the multi-cycle datapath.
// Multiply: radix-2 shift-add on magnitudes. Divide: restoring division on
// magnitudes. Signs are applied in a single fix-up cycle.
//
// state | meaning
// IDLE  | waiting for mult_start/div_start after reset
// CALC  | running WIDTH iterations on the magnitude accumulator
// FIX   | applying sign correction, writing HI_RES/LO_RES
// DONE  | result held with mult_div_done=1, new start accepted
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] HI_RES,
  output logic [WIDTH-1:0] LO_RES,
  output logic             mult_div_done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   abs_b_q;
  logic [WIDTH-1:0]   a_orig;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     hi_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes; -0x80.. wraps to the correct unsigned magnitude.
  always_comb begin
    abs_a = SrcA[WIDTH-1] ? -SrcA : SrcA;
    abs_b = SrcB[WIDTH-1] ? -SrcB : SrcB;
  end

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    hi_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, abs_b_q} : '0);
    mul_next = {hi_sum, acc[WIDTH-1:1]};
    sh       = {acc[2*WIDTH-2:0], 1'b0};
    trial    = {1'b0, sh[2*WIDTH-1:WIDTH]} - {1'b0, abs_b_q};
    div_next = trial[WIDTH] ? sh : {trial[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
  end

  // Sign fix-up: the product is negated as one 2*WIDTH value.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered outputs; the iteration timer counts down.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      abs_b_q       <= '0;
      a_orig        <= '0;
      is_div        <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      b_zero        <= 1'b0;
      HI_RES        <= '0;
      LO_RES        <= '0;
      mult_div_done <= 1'b0;
      busy          <= 1'b0;
      div_by_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (mult_start || div_start) begin
            // multiply wins when both requests arrive together
            is_div        <= !mult_start;
            a_orig        <= SrcA;
            acc           <= {{WIDTH{1'b0}}, abs_a};
            abs_b_q       <= abs_b;
            neg_q         <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
            neg_r         <= SrcA[WIDTH-1];
            b_zero        <= (SrcB == '0);
            cnt           <= CW'(WIDTH);
            busy          <= 1'b1;
            mult_div_done <= 1'b0;
            div_by_zero   <= 1'b0;
            state         <= CALC;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            HI_RES <= prod_fix[2*WIDTH-1:WIDTH];
            LO_RES <= prod_fix[WIDTH-1:0];
          end else if (b_zero) begin
            // zero divisor: dividend passes through, quotient all ones
            HI_RES      <= a_orig;
            LO_RES      <= '1;
            div_by_zero <= 1'b1;
          end else begin
            HI_RES <= rem_fix;
            LO_RES <= quo_fix;
          end
          mult_div_done <= 1'b1;
          busy          <= 1'b0;
          state         <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit: table of operations with
// hand-computed results, plus sequences for start-while-busy, reset abort
// and simultaneous starts.
module tb_mult_div_unit;

  logic        CLK;
  logic        RST;
  logic        mult_start;
  logic        div_start;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] HI_RES;
  logic [31:0] LO_RES;
  logic        mult_div_done;
  logic        busy;
  logic        div_by_zero;

  mult_div_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .mult_start(mult_start), .div_start(div_start),
    .SrcA(SrcA), .SrcB(SrcB), .HI_RES(HI_RES), .LO_RES(LO_RES),
    .mult_div_done(mult_div_done), .busy(busy), .div_by_zero(div_by_zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          do_mult;
    bit          do_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dbz;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (at negedges) for done; returns cycles since start and busy-high count.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!mult_div_done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge CLK);
      lat++;
    end
    if (!mult_div_done) chk("done_timeout", 0, 1);
  endtask

  // Caller is at a negedge; start is asserted for exactly one cycle.
  task automatic run_op(input vec_t v, input int idx);
    int lat, bcnt;
    SrcA       = v.a;
    SrcB       = v.b;
    mult_start = v.do_mult;
    div_start  = v.do_div;
    @(negedge CLK);
    mult_start = 1'b0;
    div_start  = 1'b0;
    SrcA       = 32'hDEAD_BEEF;
    SrcB       = 32'h1234_5678;
    chk($sformatf("v%0d busy_after_start", idx), busy, 1);
    chk($sformatf("v%0d done_cleared", idx), mult_div_done, 0);
    chk($sformatf("v%0d dbz_cleared", idx), div_by_zero, 0);
    wait_done(lat, bcnt);
    chk($sformatf("v%0d latency", idx), lat, 34);
    chk($sformatf("v%0d busy_cycles", idx), bcnt, 33);
    chk($sformatf("v%0d hi", idx), HI_RES, v.hi);
    chk($sformatf("v%0d lo", idx), LO_RES, v.lo);
    chk($sformatf("v%0d dbz", idx), div_by_zero, v.dbz);
  endtask

  initial begin
    int lat, bcnt;
    vec_t v;

    tbl[0]  = '{1, 0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0};
    tbl[1]  = '{1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0};
    tbl[2]  = '{0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0};
    tbl[3]  = '{0, 1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0};
    tbl[4]  = '{0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0};
    tbl[5]  = '{0, 1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1};
    tbl[6]  = '{0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 0};
    tbl[7]  = '{1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0};
    tbl[8]  = '{1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0};
    tbl[9]  = '{0, 1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 0};
    tbl[10] = '{0, 1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};
    tbl[11] = '{1, 0, 32'h0000_0000, 32'h0000_3039, 32'h0000_0000, 32'h0000_0000, 0};

    RST = 1'b1; mult_start = 1'b0; div_start = 1'b0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge CLK);
    chk("rst_hi", HI_RES, 0);
    chk("rst_lo", LO_RES, 0);
    chk("rst_done", mult_div_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dbz", div_by_zero, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Back-to-back: every op after the first starts in the first DONE cycle.
    for (int i = 0; i < 12; i++) run_op(tbl[i], i);

    // div_start during cycle 10 of a multiply is ignored: 1000 * -1000.
    SrcA = 32'd1000; SrcB = 32'hFFFF_FC18; mult_start = 1'b1;
    @(negedge CLK);
    mult_start = 1'b0;
    repeat (9) @(negedge CLK);
    div_start = 1'b1; SrcA = 32'd9; SrcB = 32'd3;
    @(negedge CLK);
    div_start = 1'b0;
    lat = 11; bcnt = 0;
    while (!mult_div_done && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
    chk("ign_latency", lat, 34);
    chk("ign_hi", HI_RES, 32'hFFFF_FFFF);
    chk("ign_lo", LO_RES, 32'hFFF0_BDC0);

    // Reset during iteration 15 aborts and clears outputs.
    SrcA = 32'd50; SrcB = 32'd60; mult_start = 1'b1;
    @(negedge CLK);
    mult_start = 1'b0;
    repeat (14) @(negedge CLK);
    chk("abort_busy_before", busy, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_done", mult_div_done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_hi", HI_RES, 0);
    chk("abort_lo", LO_RES, 0);

    // Fresh multiply after the abort.
    v = '{1, 0, 32'd3, 32'd4, 32'd0, 32'd12, 0};
    run_op(v, 100);

    // Both starts together: multiply wins.
    v = '{1, 1, 32'd6, 32'd3, 32'd0, 32'd18, 0};
    run_op(v, 101);

    // Result holds in DONE without a new start.
    repeat (5) @(negedge CLK);
    chk("hold_done", mult_div_done, 1);
    chk("hold_lo", LO_RES, 32'd18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
